// File: rtl/pm_pkg.sv
// Shared definitions for the period meter: FSM state encoding,
// default counter width and a busy decode helper.
package pm_pkg;

  // Default width of the period counter and of the reported result.
  localparam int CNT_W_DEFAULT = 32;

  // Measurement sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2,
    DONE = 2'd3
  } pm_state_e;

  // A measurement is in progress while waiting for the opening edge or counting.
  function automatic logic is_busy(input pm_state_e s);
    return (s == ARM) || (s == MEAS);
  endfunction

endpackage

// File: rtl/pm_sync.sv
// Two-flop synchronizer plus rising-edge detector for the measured signal.
// The edge output stays masked until the whole pipeline holds real samples,
// so a signal that is already high when reset is released is not mistaken
// for a 0->1 transition.
module pm_sync
  import pm_pkg::*;
(
  input  logic clkin,
  input  logic rstn,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o
);

  logic       sync1_q;
  logic       sync2_q;
  logic       prev_q;
  logic [2:0] fill_q;

  // Synchronize the input, keep the previous synchronized sample and track pipeline fill.
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      fill_q  <= 3'b000;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      fill_q  <= {fill_q[1:0], 1'b1};
    end
  end

  assign sync_o = sync2_q;
  assign rise_o = sync2_q & ~prev_q & fill_q[2];

endmodule

// File: rtl/period_meter.sv
// Period meter: counts clkin cycles between two consecutive rising edges
// of an asynchronous input signal, saturating (and flagging overflow) when
// no edge arrives in time. CONTINUOUS=1 chains measurements back to back.
// Optional build macro PERIOD_METER_HIGHTIME_EN adds a 'hightime' output
// reporting how many cycles the synchronized signal was high in the period.
module period_meter
  import pm_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEFAULT,
  parameter int CONTINUOUS = 0
) (
  input  logic             clkin,
  input  logic             rstn,
  input  logic             sigin,
  input  logic             start,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] period,
  output logic             ovf
`ifdef PERIOD_METER_HIGHTIME_EN
  ,
  output logic [CNT_W-1:0] hightime
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_SAT_AT = CNT_MAX - CNT_ONE;

  pm_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] period_q;
  logic             ovf_q;
  logic             valid_q;
  logic             sig_sync;
  logic             sig_rise;
  logic             edge_seen;
`ifdef PERIOD_METER_HIGHTIME_EN
  logic [CNT_W-1:0] high_cnt_q;
  logic [CNT_W-1:0] high_cnt_d;
  logic [CNT_W-1:0] hightime_q;
`endif

  pm_sync u_sync (
    .clkin   (clkin),
    .rstn    (rstn),
    .async_i (sigin),
    .sync_o  (sig_sync),
    .rise_o  (sig_rise)
  );

  // An edge is accepted only while the synchronized level agrees with it.
  assign edge_seen = sig_rise & sig_sync;

  // Next counter values: the period count always advances by one, the high count by the level.
  always_comb begin
    cnt_d = cnt_q + CNT_ONE;
`ifdef PERIOD_METER_HIGHTIME_EN
    high_cnt_d = high_cnt_q + {{(CNT_W-1){1'b0}}, sig_sync};
`endif
  end

  // Measurement sequencer with its counter and registered result outputs.
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      period_q   <= '0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
`ifdef PERIOD_METER_HIGHTIME_EN
      high_cnt_q <= '0;
      hightime_q <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= ARM;
            cnt_q   <= '0;
          end
        end
        ARM: begin
          if (edge_seen) begin
            state_q    <= MEAS;
            cnt_q      <= CNT_ONE;
`ifdef PERIOD_METER_HIGHTIME_EN
            high_cnt_q <= CNT_ONE;
`endif
          end else if (cnt_q == CNT_SAT_AT) begin
            state_q    <= DONE;
            cnt_q      <= CNT_MAX;
            period_q   <= CNT_MAX;
            ovf_q      <= 1'b1;
            valid_q    <= 1'b1;
`ifdef PERIOD_METER_HIGHTIME_EN
            hightime_q <= CNT_MAX;
`endif
          end else begin
            cnt_q <= cnt_d;
          end
        end
        MEAS: begin
          if (edge_seen) begin
            // The closing edge is also the opening edge of a chained measurement.
            state_q    <= DONE;
            period_q   <= cnt_q;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b1;
            cnt_q      <= CNT_ONE;
`ifdef PERIOD_METER_HIGHTIME_EN
            hightime_q <= high_cnt_q;
            high_cnt_q <= CNT_ONE;
`endif
          end else if (cnt_q == CNT_SAT_AT) begin
            state_q    <= DONE;
            cnt_q      <= CNT_MAX;
            period_q   <= CNT_MAX;
            ovf_q      <= 1'b1;
            valid_q    <= 1'b1;
`ifdef PERIOD_METER_HIGHTIME_EN
            hightime_q <= CNT_MAX;
`endif
          end else begin
            cnt_q      <= cnt_d;
`ifdef PERIOD_METER_HIGHTIME_EN
            high_cnt_q <= high_cnt_d;
`endif
          end
        end
        DONE: begin
          if ((CONTINUOUS != 0) && !ovf_q) begin
            // The next period is already running; keep counting through this cycle.
            state_q    <= MEAS;
            cnt_q      <= cnt_d;
`ifdef PERIOD_METER_HIGHTIME_EN
            high_cnt_q <= high_cnt_d;
`endif
          end else if (CONTINUOUS != 0) begin
            state_q <= ARM;
            cnt_q   <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = is_busy(state_q);
  assign valid  = valid_q;
  assign period = period_q;
  assign ovf    = ovf_q;
`ifdef PERIOD_METER_HIGHTIME_EN
  assign hightime = hightime_q;
`endif

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter: three instances (single-shot 32-bit,
// continuous 32-bit, single-shot 4-bit). Stimulus pushes expected results
// into per-instance queues; monitors pop and compare on every valid pulse.
module tb_period_meter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  logic sigA, sigB, sigC;
  logic startA, startB, startC;
  logic busyA, busyB, busyC;
  logic validA, validB, validC;
  logic ovfA, ovfB, ovfC;
  logic [31:0] periodA, periodB;
  logic [3:0]  periodC;
`ifdef PERIOD_METER_HIGHTIME_EN
  logic [31:0] htA, htB;
  logic [3:0]  htC;
`endif

  period_meter #(.CNT_W(32), .CONTINUOUS(0)) u_a (
    .clkin(clk), .rstn(rstn), .sigin(sigA), .start(startA),
    .busy(busyA), .valid(validA), .period(periodA), .ovf(ovfA)
`ifdef PERIOD_METER_HIGHTIME_EN
    , .hightime(htA)
`endif
  );

  period_meter #(.CNT_W(32), .CONTINUOUS(1)) u_b (
    .clkin(clk), .rstn(rstn), .sigin(sigB), .start(startB),
    .busy(busyB), .valid(validB), .period(periodB), .ovf(ovfB)
`ifdef PERIOD_METER_HIGHTIME_EN
    , .hightime(htB)
`endif
  );

  period_meter #(.CNT_W(4), .CONTINUOUS(0)) u_c (
    .clkin(clk), .rstn(rstn), .sigin(sigC), .start(startC),
    .busy(busyC), .valid(validC), .period(periodC), .ovf(ovfC)
`ifdef PERIOD_METER_HIGHTIME_EN
    , .hightime(htC)
`endif
  );

  typedef struct {
    logic [31:0] period;
    logic        ovf;
    logic [31:0] ht;
    int          gap;
  } exp_t;

  exp_t qA[$];
  exp_t qB[$];
  exp_t qC[$];
  exp_t eA, eB, eC;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lastA = 0, lastB = 0, lastC = 0;

  int hiA = 5, loA = 5, hiB = 7, loB = 6, hiC = 3, loC = 3;
  bit togA = 0, togB = 0, togC = 0;

  always @(posedge clk) cyc++;

  function automatic exp_t mkExp(input int p, input bit o, input int h, input int g);
    exp_t e;
    e.period = p;
    e.ovf    = o;
    e.ht     = h;
    e.gap    = g;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic int qSize(input int sel);
    case (sel)
      0:       return qA.size();
      1:       return qB.size();
      default: return qC.size();
    endcase
  endfunction

  // Signal generators: high for hi cycles, low for lo cycles, changed on negedges.
  always begin
    if (togA) begin
      sigA = 1'b1; repeat (hiA) @(negedge clk);
      sigA = 1'b0; repeat (loA) @(negedge clk);
    end else @(negedge clk);
  end
  always begin
    if (togB) begin
      sigB = 1'b1; repeat (hiB) @(negedge clk);
      sigB = 1'b0; repeat (loB) @(negedge clk);
    end else @(negedge clk);
  end
  always begin
    if (togC) begin
      sigC = 1'b1; repeat (hiC) @(negedge clk);
      sigC = 1'b0; repeat (loC) @(negedge clk);
    end else @(negedge clk);
  end

  // Monitors: compare every valid pulse against the next queued expectation.
  always @(negedge clk) begin
    if (rstn && validA === 1'b1) begin
      if (qA.size() == 0) checkOutput("A unexpected valid", {31'd0, validA}, 32'd0);
      else begin
        eA = qA.pop_front();
        checkOutput("A period", periodA, eA.period);
        checkOutput("A ovf", {31'd0, ovfA}, {31'd0, eA.ovf});
        checkOutput("A busy at valid", {31'd0, busyA}, 32'd0);
`ifdef PERIOD_METER_HIGHTIME_EN
        checkOutput("A hightime", htA, eA.ht);
`endif
        if (eA.gap != 0) checkOutput("A latency", cyc - lastA, eA.gap);
      end
      lastA = cyc;
    end
  end

  always @(negedge clk) begin
    if (rstn && validB === 1'b1) begin
      if (qB.size() == 0) checkOutput("B unexpected valid", {31'd0, validB}, 32'd0);
      else begin
        eB = qB.pop_front();
        checkOutput("B period", periodB, eB.period);
        checkOutput("B ovf", {31'd0, ovfB}, {31'd0, eB.ovf});
        checkOutput("B busy at valid", {31'd0, busyB}, 32'd0);
`ifdef PERIOD_METER_HIGHTIME_EN
        checkOutput("B hightime", htB, eB.ht);
`endif
        if (eB.gap != 0) checkOutput("B valid spacing", cyc - lastB, eB.gap);
      end
      lastB = cyc;
    end
  end

  always @(negedge clk) begin
    if (rstn && validC === 1'b1) begin
      if (qC.size() == 0) checkOutput("C unexpected valid", {31'd0, validC}, 32'd0);
      else begin
        eC = qC.pop_front();
        checkOutput("C period", {28'd0, periodC}, eC.period);
        checkOutput("C ovf", {31'd0, ovfC}, {31'd0, eC.ovf});
        checkOutput("C busy at valid", {31'd0, busyC}, 32'd0);
`ifdef PERIOD_METER_HIGHTIME_EN
        checkOutput("C hightime", {28'd0, htC}, eC.ht);
`endif
        if (eC.gap != 0) checkOutput("C latency", cyc - lastC, eC.gap);
      end
      lastC = cyc;
    end
  end

  // One-cycle start pulse, issued from a negedge and returning on the next one.
  task automatic applyStimulus(input int sel);
    case (sel)
      0:       begin startA = 1'b1; lastA = cyc; end
      1:       begin startB = 1'b1; lastB = cyc; end
      default: begin startC = 1'b1; lastC = cyc; end
    endcase
    @(negedge clk);
    startA = 1'b0;
    startB = 1'b0;
    startC = 1'b0;
  endtask

  // Wait for the monitor to consume all expectations of one instance, bounded.
  task automatic waitDrain(input int sel, input int budget);
    int n = 0;
    while (qSize(sel) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("expected results delivered", qSize(sel), 0);
    case (sel)
      0:       qA.delete();
      1:       qB.delete();
      default: qC.delete();
    endcase
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired: simulation did not complete");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rstn = 1'b0;
    sigA = 1'b0; sigB = 1'b0; sigC = 1'b0;
    startA = 1'b0; startB = 1'b0; startC = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    checkOutput("A busy in reset", {31'd0, busyA}, 32'd0);
    checkOutput("A valid in reset", {31'd0, validA}, 32'd0);
    checkOutput("A period in reset", periodA, 32'd0);
    checkOutput("A ovf in reset", {31'd0, ovfA}, 32'd0);
    checkOutput("B busy in reset", {31'd0, busyB}, 32'd0);
    checkOutput("C period in reset", {28'd0, periodC}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Toggle every 5 cycles: period 10
    hiA = 5; loA = 5; togA = 1;
    repeat (20) @(negedge clk);
    checkOutput("A busy idle", {31'd0, busyA}, 32'd0);
    qA.push_back(mkExp(10, 0, 5, 0));
    applyStimulus(0);
    checkOutput("A busy one cycle after start", {31'd0, busyA}, 32'd1);
    waitDrain(0, 100);
    @(negedge clk);
    checkOutput("A busy after done", {31'd0, busyA}, 32'd0);

    // High 3 / low 7, with an ignored start while busy
    hiA = 3; loA = 7;
    repeat (25) @(negedge clk);
    qA.push_back(mkExp(10, 0, 3, 0));
    applyStimulus(0);
    repeat (5) @(negedge clk);
    applyStimulus(0);
    waitDrain(0, 100);
    repeat (30) @(negedge clk);
    checkOutput("A period held", periodA, 32'd10);

    // High 7 / low 6: period 13
    hiA = 7; loA = 6;
    repeat (30) @(negedge clk);
    qA.push_back(mkExp(13, 0, 7, 0));
    applyStimulus(0);
    waitDrain(0, 100);

    // Reset in the middle of a long measurement
    hiA = 20; loA = 20;
    repeat (90) @(negedge clk);
    applyStimulus(0);
    repeat (25) @(negedge clk);
    checkOutput("A busy before reset", {31'd0, busyA}, 32'd1);
    rstn = 1'b0;
    #1;
    checkOutput("A busy at reset", {31'd0, busyA}, 32'd0);
    checkOutput("A valid at reset", {31'd0, validA}, 32'd0);
    checkOutput("A period at reset", periodA, 32'd0);
    checkOutput("A ovf at reset", {31'd0, ovfA}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (100) @(negedge clk);
    checkOutput("A busy after reset release", {31'd0, busyA}, 32'd0);

    // Signal held high across reset release is not an edge
    togA = 0;
    repeat (45) @(negedge clk);
    sigA = 1'b1;
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    qA.push_back(mkExp(8, 0, 4, 0));
    applyStimulus(0);
    repeat (5) @(negedge clk);
    sigA = 1'b0;
    repeat (4) @(negedge clk);
    hiA = 4; loA = 4; togA = 1;
    waitDrain(0, 100);
    togA = 0;

    // 4-bit counter, static low input: overflow in ARM after 15 counts
    sigC = 1'b0;
    qC.push_back(mkExp(15, 1, 15, 16));
    applyStimulus(2);
    waitDrain(2, 100);

    // 4-bit counter, period 6
    hiC = 3; loC = 3; togC = 1;
    repeat (20) @(negedge clk);
    qC.push_back(mkExp(6, 0, 3, 0));
    applyStimulus(2);
    waitDrain(2, 100);

    // 4-bit counter: one opening edge, then no closing edge -> overflow in MEAS
    togC = 0;
    repeat (10) @(negedge clk);
    sigC = 1'b0;
    repeat (5) @(negedge clk);
    qC.push_back(mkExp(15, 1, 15, 0));
    applyStimulus(2);
    repeat (3) @(negedge clk);
    sigC = 1'b1;
    waitDrain(2, 100);

    // Continuous mode: back-to-back periods of 13
    hiB = 7; loB = 6; togB = 1;
    repeat (30) @(negedge clk);
    qB.push_back(mkExp(13, 0, 7, 0));
    qB.push_back(mkExp(13, 0, 7, 13));
    qB.push_back(mkExp(13, 0, 7, 13));
    applyStimulus(1);
    waitDrain(1, 200);
    rstn = 1'b0;
    #1;
    checkOutput("B period at reset", periodB, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    togB = 0;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
